// File: rtl/ahbl_pkg.sv
// Shared definitions for the two-master AHB-Lite arbiter: transfer-type
// encodings, the master-index type and the address-phase request record.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef logic mst_idx_t;

  localparam mst_idx_t MST_M0 = 1'b0;
  localparam mst_idx_t MST_M1 = 1'b1;

  // Address-phase control that must be replayed for a losing master.
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
  } ahbl_req_t;

endpackage

// File: rtl/ahbl_arb_hold.sv
// Per-master holding stage: captures a losing (or stalled) address phase,
// flags it as pending, and presents the live request (held one first).
module ahbl_arb_hold
  import ahbl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_nonseq,  // master HTRANS[1]
  input  logic [31:0] i_haddr,
  input  logic [2:0]  i_hsize,
  input  logic        i_hwrite,
  input  logic        i_mst_hready,  // this master's own HREADY as driven by the arbiter
  input  logic        i_grant,       // live request forwarded on the bus this cycle
  output logic        o_live,
  output logic        o_pend,
  output ahbl_req_t   o_req
);

  logic      r_pend;
  ahbl_req_t r_held;
  logic      w_fresh;
  logic      w_capture;
  ahbl_req_t w_fresh_req;

  // A fresh request only exists while the master sees itself ready; a pending
  // master is stalled, so capture and release never coincide.
  assign w_fresh     = i_req_nonseq & i_mst_hready;
  assign w_capture   = w_fresh & ~i_grant;
  assign w_fresh_req = '{addr: i_haddr, size: i_hsize, write: i_hwrite};

  assign o_live = r_pend | w_fresh;
  assign o_pend = r_pend;
  assign o_req  = r_pend ? r_held : w_fresh_req;

  // Holding register and pend flag: set on capture, cleared when replayed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= 1'b0;
      r_held <= '0;
    end else if (w_capture) begin
      r_pend <= 1'b1;
      r_held <= w_fresh_req;
    end else if (i_grant && r_pend) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= r_pend;
    end
  end

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter (M0 = CPU wrapper, M1 = DMA). Uncontended
// transfers pass straight through; losers are held and replayed.
// Optional macro AHBL_ARB_RR_EN: round-robin contention instead of fixed
// M0 priority.
module ahbl_master_arbiter
  import ahbl_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic [2:0]  M0_HSIZE,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY
);

  logic      w_live0, w_live1, w_pend0, w_pend1;
  ahbl_req_t w_req0, w_req1;
  logic      w_gnt_vld, w_grant0, w_grant1;
  mst_idx_t  w_gnt_idx;
  ahbl_req_t w_bus_req, r_bus_req;
  logic [1:0] w_bus_trans, r_bus_trans;
  logic      r_d_vld;
  mst_idx_t  r_d_own;
  logic      w_m0_hready, w_m1_hready;
  logic      w_unused_htrans;

  // Only HTRANS[1] distinguishes NONSEQ from IDLE for these masters.
  assign w_unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];

  ahbl_arb_hold u_hold0 (
    .i_clk(HCLK), .i_rst_n(HRESETn), .i_req_nonseq(M0_HTRANS[1]),
    .i_haddr(M0_HADDR), .i_hsize(M0_HSIZE), .i_hwrite(M0_HWRITE),
    .i_mst_hready(w_m0_hready), .i_grant(w_grant0),
    .o_live(w_live0), .o_pend(w_pend0), .o_req(w_req0)
  );

  ahbl_arb_hold u_hold1 (
    .i_clk(HCLK), .i_rst_n(HRESETn), .i_req_nonseq(M1_HTRANS[1]),
    .i_haddr(M1_HADDR), .i_hsize(M1_HSIZE), .i_hwrite(M1_HWRITE),
    .i_mst_hready(w_m1_hready), .i_grant(w_grant1),
    .o_live(w_live1), .o_pend(w_pend1), .o_req(w_req1)
  );

`ifdef AHBL_ARB_RR_EN
  mst_idx_t r_rr_ptr;  // master that wins the next contested grant
  logic     w_contest;
  assign w_contest = HREADY & w_live0 & w_live1;

  // Round-robin pointer: flips to the loser after every contested grant.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rr_ptr <= MST_M0;
    end else if (w_contest) begin
      r_rr_ptr <= ~w_gnt_idx;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  // Grant decision, only while the slave accepts a new address phase.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = MST_M0;
    if (HREADY) begin
      if (w_live0 && w_live1) begin
        w_gnt_vld = 1'b1;
`ifdef AHBL_ARB_RR_EN
        w_gnt_idx = r_rr_ptr;
`else
        w_gnt_idx = MST_M0;
`endif
      end else if (w_live0) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = MST_M0;
      end else if (w_live1) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = MST_M1;
      end else begin
        w_gnt_vld = 1'b0;
      end
    end else begin
      w_gnt_vld = 1'b0;
    end
  end

  assign w_grant0 = w_gnt_vld & (w_gnt_idx == MST_M0);
  assign w_grant1 = w_gnt_vld & (w_gnt_idx == MST_M1);

  // Address-phase mux: winner's live request, or an all-zero IDLE.
  always_comb begin
    w_bus_req   = '0;
    w_bus_trans = HTRANS_IDLE;
    if (w_gnt_vld) begin
      w_bus_trans = HTRANS_NONSEQ;
      case (w_gnt_idx)
        MST_M0:  w_bus_req = w_req0;
        MST_M1:  w_bus_req = w_req1;
        default: w_bus_req = '0;
      endcase
    end else begin
      w_bus_req = '0;
    end
  end

  // Last presented address phase, re-driven while the slave stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_bus_req   <= '0;
      r_bus_trans <= HTRANS_IDLE;
    end else if (HREADY) begin
      r_bus_req   <= w_bus_req;
      r_bus_trans <= w_bus_trans;
    end else begin
      r_bus_req   <= r_bus_req;
      r_bus_trans <= r_bus_trans;
    end
  end

  assign HADDR  = HREADY ? w_bus_req.addr  : r_bus_req.addr;
  assign HSIZE  = HREADY ? w_bus_req.size  : r_bus_req.size;
  assign HWRITE = HREADY ? w_bus_req.write : r_bus_req.write;
  assign HTRANS = HREADY ? w_bus_trans     : r_bus_trans;

  // Data-phase owner: advances on HREADY, frozen while the slave stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_d_vld <= 1'b0;
      r_d_own <= MST_M0;
    end else if (HREADY) begin
      r_d_vld <= w_gnt_vld;
      r_d_own <= w_gnt_vld ? w_gnt_idx : r_d_own;
    end else begin
      r_d_vld <= r_d_vld;
      r_d_own <= r_d_own;
    end
  end

  // Write data follows the data-phase owner.
  always_comb begin
    HWDATA = 32'h0000_0000;
    if (r_d_vld) begin
      case (r_d_own)
        MST_M0:  HWDATA = M0_HWDATA;
        MST_M1:  HWDATA = M1_HWDATA;
        default: HWDATA = 32'h0000_0000;
      endcase
    end else begin
      HWDATA = 32'h0000_0000;
    end
  end

  // Per-master ready: stalled while pending, else tracks its own data phase.
  assign w_m0_hready = w_pend0 ? 1'b0 : ((r_d_vld && r_d_own == MST_M0) ? HREADY : 1'b1);
  assign w_m1_hready = w_pend1 ? 1'b0 : ((r_d_vld && r_d_own == MST_M1) ? HREADY : 1'b1);
  assign M0_HREADY   = w_m0_hready;
  assign M1_HREADY   = w_m1_hready;
  assign M0_HRDATA   = HRDATA;
  assign M1_HRDATA   = HRDATA;

endmodule

// File: doc/ahbl_master_arbiter.md
# ahbl_master_arbiter

Two-master AHB-Lite arbiter sharing the single AHB-Lite master port of the SoC bus between the CPU wrapper (M0) and a second master such as a DMA engine (M1). The arbiter forwards an uncontended transfer with zero added latency. A losing transfer's address phase is captured into a per-master holding register and replayed later. The losing master is stalled through its own HREADY until its data phase completes. Only NONSEQ and IDLE transfers are supported, matching the masters in this codebase.

## Interface
- No parameters; address and data are 32 bits.
- HCLK  in  1  system clock
- HRESETn  in  1  reset, asynchronous, active-low
- M0_HADDR, M1_HADDR  in  32  master address
- M0_HTRANS, M1_HTRANS  in  2  master transfer type; only IDLE (00) and NONSEQ (10) are used
- M0_HSIZE, M1_HSIZE  in  3  master transfer size
- M0_HWRITE, M1_HWRITE  in  1  master write control
- M0_HWDATA, M1_HWDATA  in  32  master write data
- M0_HREADY, M1_HREADY  out  1  per-master ready/stall
- M0_HRDATA, M1_HRDATA  out  32  read data; the slave HRDATA broadcast to both masters
- HADDR, HTRANS, HSIZE, HWRITE, HWDATA  out  32/2/3/1/32  shared bus master outputs
- HRDATA  in  32  slave read data
- HREADY  in  1  slave ready

## Operation
- **Request.** A master presents a request when its HTRANS[1]=1 while its own Mx_HREADY=1. That address phase is accepted by the arbiter in that cycle.
- **Live request.** A master's live request is either its held request (pend_x=1) or a fresh request. A held request is always selected over a fresh one from the same master.
- **Grant.**
  - Address ownership is decided combinationally only while the slave HREADY=1.
  - With one live requester, that master wins.
  - With two live requesters, M0 wins by default; see Configuration for the alternative.
- **Winner path.**
  - The winner's request drives HADDR, HSIZE and HWRITE from its holding register or its live inputs, with HTRANS=NONSEQ.
  - The winner becomes the data-phase owner in the next cycle: d_own <= x, d_vld <= 1.
- **Loser path.** A loser's fresh request is latched into its holding register and pend_x is set. pend_x clears in the cycle its held request is forwarded.
- **No requester.** HTRANS=IDLE, and HADDR, HSIZE and HWRITE are 0.
- **Slave stall (HREADY=0).**
  - HADDR, HTRANS, HSIZE and HWRITE are held unchanged.
  - d_own and d_vld are held.
  - Fresh requests arriving in this cycle are still captured into their holding registers.
- **Write data and read data.**
  - HWDATA is Mx_HWDATA of d_own when d_vld=1, otherwise 0.
  - HRDATA goes to both masters unmodified.
- **Per-master ready.** Mx_HREADY = 0 if pend_x=1; else HREADY if d_vld=1 and d_own=x; else 1.
- **Data-phase clear.** d_vld clears when HREADY=1 and no new address phase is forwarded.

## Timing
- **Reset values.**
  - HTRANS=00; HADDR, HSIZE, HWRITE and HWDATA are 0.
  - M0_HREADY=M1_HREADY=1; pend_0=pend_1=0; d_vld=0.
  - The round-robin pointer (when enabled) points to M0.
- **Latency.**
  - An uncontended transfer has 0 added cycles; the address passes straight through.
  - A held transfer adds at least 1 cycle, plus the remaining data phase of the transfer that won.
- **Back-to-back requests.** A master issuing consecutive NONSEQ transfers while it keeps winning sustains 1 transfer per cycle, provided the slave HREADY stays 1.
- **Simultaneous requests in the same cycle.** One request is forwarded and the other is held. The held request is forwarded in the next HREADY=1 cycle unless the other master has priority and has a new live request.
- **Holding-register overflow.** Cannot occur: a master with pend_x=1 sees Mx_HREADY=0 and therefore cannot issue another request.
- **Reset mid-operation.** All held requests and any in-flight ownership are dropped. No replay occurs after reset.

## Configuration
- **AHBL_ARB_RR_EN defined.**
  - Two-master contention is resolved round-robin: the master that did not win the last contested grant wins the next.
  - The pointer updates only on contested grants.
- **AHBL_ARB_RR_EN not defined.**
  - Fixed priority, M0 always wins.
  - M1 can be starved while M0 issues back-to-back requests.

## Structure
- **Package ahbl_pkg:** HTRANS encodings HTRANS_IDLE=2'b00 and HTRANS_NONSEQ=2'b10, and the 1-bit master-index type.
- **Sub-module ahbl_arb_hold:** one instance per master. It contains the address/size/write holding register, pend flag and live-request mux, with a capture/release handshake to the top.
- **Top level:** grant logic, the data-phase owner register, the output muxes and the HREADY fan-out.

## Test plan
- **Reset.** Assert HRESETn=0 -> HTRANS=00, both Mx_HREADY=1. Release reset, M0 reads 0x0000_1000 -> HADDR=0x1000 in the same cycle, M0_HREADY follows the slave HREADY.
- **Simultaneous request.**
  - Stimulus: M0 writes 0x2000 and M1 reads 0x3000 in the same cycle; slave HREADY=1.
  - Response: 0x2000 is forwarded; M1_HREADY=0 for 1 cycle; 0x3000 is forwarded in the next cycle; HWDATA carries M0_HWDATA during cycle 2.
- **Slave stall.** Slave HREADY=0 for 3 cycles during M1's data phase -> HADDR is held, M1_HREADY=0 for 3 cycles, and M0's fresh request is latched and forwarded after the stall.
- **Starvation / round-robin.**
  - Stimulus: M0 and M1 both request continuously for 6 cycles.
  - Response with AHBL_ARB_RR_EN: grants alternate M0, M1, M0, …
  - Response without it: M0 wins all 6 and M1_HREADY stays 0.
- **Reset mid-transfer.** Assert reset while pend_1=1 -> after release, no transfer to M1's held address appears.
